// File: rtl/bcd_mod_counter_display.sv
// Purpose: BCD modulo-MODULUS counter (1..8 digits) with run/pause, up/down, load, cascade input and multiplexed 7-segment drive.
// Latency: count/carry_out update one clk after the step or load; seg_com/seg_data are registered one clk after index/count change.
// Backpressure: none; run=0 holds count and prescaler, while the display scan keeps running.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   run, casc_in, up     count enable, cascade step strobe (CASCADE=1), direction
//   load, load_val       synchronous load of a BCD value (invalid values load 0)
//   count, carry_out     current BCD count, one-cycle wrap pulse
//   seg_com, seg_data    active-low digit select, active-high segments {a..g,dp}
module bcd_mod_counter_display #(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 60,
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 1000,
    parameter int CASCADE  = 0,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  casc_in,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic [7:0]            seg_com,
    output logic [7:0]            seg_data
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [CW-1:0] int_to_bcd(input int v);
        logic [CW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hFC;
            4'd1:    g = 8'h60;
            4'd2:    g = 8'hDA;
            4'd3:    g = 8'hF2;
            4'd4:    g = 8'h66;
            4'd5:    g = 8'hB6;
            4'd6:    g = 8'hBE;
            4'd7:    g = 8'hE0;
            4'd8:    g = 8'hFE;
            4'd9:    g = 8'hF6;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Highest legal count in BCD; used both as the up-wrap point and the down-wrap target.
    localparam logic [CW-1:0] MAX_BCD  = int_to_bcd(MODULUS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] scan_tmr;
    logic [2:0]    scan_idx;
    logic          step;
    logic          load_ok;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_dec;
    logic [31:0]   cnt_pad;
    logic [7:0]    lz_mask;
    logic [3:0]    sel_digit;
    logic          sel_blank;

    // ---------------- step generation ----------------
    always_comb begin
        step = 1'b0;
        if (CASCADE != 0) begin
            step = run & casc_in;
        end else begin
            step = run & (pre_cnt == PRE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if ((CASCADE != 0) || load) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    // ---------------- BCD arithmetic ----------------
    // Per-digit ripple: a 9 (or 0 when decrementing) rolls over and passes the carry up.
    always_comb begin
        logic ci;
        logic bi;
        cnt_inc = count;
        cnt_dec = count;
        ci      = 1'b1;
        bi      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ci) begin
                if (count[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    ci                = 1'b0;
                end
            end
            if (bi) begin
                if (count[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    bi                = 1'b0;
                end
            end
        end
    end

    // With every nibble a valid decimal digit, packed BCD orders like the number itself.
    always_comb begin
        load_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            if (load) begin
                count <= load_ok ? load_val : '0;
            end else if (step) begin
                if (up) begin
                    if (count == MAX_BCD) begin
                        count     <= '0;
                        carry_out <= 1'b1;
                    end else begin
                        count <= cnt_inc;
                    end
                end else begin
                    if (count == '0) begin
                        count     <= MAX_BCD;
                        carry_out <= 1'b1;
                    end else begin
                        count <= cnt_dec;
                    end
                end
            end
        end
    end

    // ---------------- display scan ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_tmr <= '0;
            scan_idx <= '0;
        end else if (scan_tmr == SCN_LAST) begin
            scan_tmr <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            scan_tmr <= scan_tmr + SW'(1);
        end
    end

    assign cnt_pad   = 32'(count);
    assign sel_digit = cnt_pad[{scan_idx, 2'b00} +: 4];

    // lz_mask[i] is set when digit i and every digit above it are zero; digit 0 is never blanked.
    always_comb begin
        logic hz;
        lz_mask = '0;
        hz      = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            hz         = hz & (cnt_pad[4*i +: 4] == 4'd0);
            lz_mask[i] = hz;
        end
    end

    assign sel_blank = (BLANK_LZ != 0) && lz_mask[scan_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_com  <= 8'hFE;
            seg_data <= 8'hFC;
        end else begin
            seg_com  <= ~(8'b1 << scan_idx);
            seg_data <= sel_blank ? 8'h00 : glyph(sel_digit);
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter_display.sv
module tb_bcd_mod_counter_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       run0, casc0, up0, load0;
    logic [7:0] lv0, cnt0, com0, dat0;
    logic       co0;
    logic       run1, casc1, up1, load1;
    logic [7:0] lv1, cnt1, com1, dat1;
    logic       co1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_mod_counter_display #(
        .DIGITS(2), .MODULUS(60), .TICK_DIV(4), .SCAN_DIV(2), .CASCADE(0), .BLANK_LZ(0)
    ) dut0 (
        .clk(clk), .rst(rst), .run(run0), .casc_in(casc0), .up(up0), .load(load0),
        .load_val(lv0), .count(cnt0), .carry_out(co0), .seg_com(com0), .seg_data(dat0)
    );

    bcd_mod_counter_display #(
        .DIGITS(2), .MODULUS(60), .TICK_DIV(4), .SCAN_DIV(2), .CASCADE(1), .BLANK_LZ(1)
    ) dut1 (
        .clk(clk), .rst(rst), .run(run1), .casc_in(casc1), .up(up1), .load(load1),
        .load_val(lv1), .count(cnt1), .carry_out(co1), .seg_com(com1), .seg_data(dat1)
    );

    typedef struct {
        logic [7:0] lv;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] sb_q[$];
    logic [8:0] sb9_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk_reset();
        chk("rst_count0", cnt0, 8'h00);
        chk("rst_carry0", {7'd0, co0}, 8'h00);
        chk("rst_com0", com0, 8'hFE);
        chk("rst_data0", dat0, 8'hFC);
        chk("rst_count1", cnt1, 8'h00);
        chk("rst_com1", com1, 8'hFE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] e9;
        int         idx;
        rst = 1'b1;
        run0 = 0; casc0 = 0; up0 = 1; load0 = 0; lv0 = 8'h00;
        run1 = 0; casc1 = 0; up1 = 1; load1 = 0; lv1 = 8'h00;
        vecs[0] = '{8'h7A, 8'h00};
        vecs[1] = '{8'h65, 8'h00};
        vecs[2] = '{8'h42, 8'h42};
        vecs[3] = '{8'h59, 8'h59};
        vecs[4] = '{8'h60, 8'h00};
        vecs[5] = '{8'h9F, 8'h00};
        vecs[6] = '{8'h00, 8'h00};
        vecs[7] = '{8'h37, 8'h37};

        // reset from power-up
        tick(2);
        chk_reset();
        rst = 1'b0;

        // free-running up count: one step every 4 cycles, wrap at 240
        run0 = 1; up0 = 1;
        for (int e = 1; e <= 241; e++) begin
            tick();
            chk("up_count", cnt0, bcd((e / 4) % 60));
            chk("up_carry", {7'd0, co0}, (e == 240) ? 8'h01 : 8'h00);
        end

        // load table, applied while paused
        run0 = 0;
        for (int i = 0; i < 8; i++) begin
            load0 = 1; lv0 = vecs[i].lv;
            sb_q.push_back(vecs[i].exp);
            tick();
            load0 = 0;
            chk("load_val", cnt0, sb_q.pop_front());
            chk("load_carry", {7'd0, co0}, 8'h00);
        end

        // down count from 0: borrow wraps to 59, then 58
        load0 = 1; lv0 = 8'h00; tick(); load0 = 0;
        up0 = 0; run0 = 1;
        tick(3);
        chk("down_hold", cnt0, 8'h00);
        tick();
        chk("down_wrap", cnt0, 8'h59);
        chk("down_borrow", {7'd0, co0}, 8'h01);
        tick();
        chk("down_borrow_end", {7'd0, co0}, 8'h00);
        tick(3);
        chk("down_58", cnt0, 8'h58);
        chk("down_58_carry", {7'd0, co0}, 8'h00);

        // load coinciding with a step that would otherwise wrap
        run0 = 0; up0 = 1;
        load0 = 1; lv0 = 8'h59; run0 = 1; tick(); load0 = 0;
        tick(3);
        load0 = 1; lv0 = 8'h59; tick(); load0 = 0;
        chk("load_step_count", cnt0, 8'h59);
        chk("load_step_carry", {7'd0, co0}, 8'h00);
        tick(3);
        chk("after_load_hold", cnt0, 8'h59);
        tick();
        chk("after_load_wrap", cnt0, 8'h00);
        chk("after_load_carry", {7'd0, co0}, 8'h01);

        // pause with prescaler at 2
        run0 = 0;
        load0 = 1; lv0 = 8'h17; run0 = 1; tick(); load0 = 0;
        tick(2);
        run0 = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("pause_count", cnt0, 8'h17);
        end
        run0 = 1;
        tick();
        chk("resume_1", cnt0, 8'h17);
        tick();
        chk("resume_2", cnt0, 8'h18);
        run0 = 0;

        // reset mid-count
        rst = 1; tick(2);
        chk_reset();
        rst = 0;

        // cascade stage: only casc_in steps the count
        load1 = 1; lv1 = 8'h58; tick(); load1 = 0;
        run1 = 1; up1 = 1;
        chk("casc_load", cnt1, 8'h58);
        tick(10);
        chk("casc_idle", cnt1, 8'h58);
        for (int p = 0; p < 3; p++) begin
            sb9_q.push_back({(p == 1), bcd((58 + p + 1) % 60)});
            casc1 = 1; tick(); casc1 = 0;
            e9 = sb9_q.pop_front();
            chk("casc_count", cnt1, e9[7:0]);
            chk("casc_carry", {7'd0, co1}, {7'd0, e9[8]});
            tick(2);
            chk("casc_carry_end", {7'd0, co1}, 8'h00);
        end
        run1 = 0;

        // scan and leading-zero blanking with count 07
        rst = 1; tick(); rst = 0;
        load0 = 1; lv0 = 8'h07; load1 = 1; lv1 = 8'h07;
        tick();
        load0 = 0; load1 = 0;
        for (int n = 2; n <= 13; n++) begin
            tick();
            idx = ((n - 1) / 2) % 2;
            chk("scan_com0", com0, (idx == 1) ? 8'hFD : 8'hFE);
            chk("scan_com1", com1, (idx == 1) ? 8'hFD : 8'hFE);
            chk("scan_dat0", dat0, (idx == 1) ? 8'hFC : 8'hE0);
            chk("scan_dat1_blank", dat1, (idx == 1) ? 8'h00 : 8'hE0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
